// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry i is the glyph for nibble value i (index 15 is the MSB group).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit scanned seven-segment driver with frame-aligned double buffering
// of the Hex word and a sticky halt indication on the decimal points.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Load,
  input  logic [31:0] Hex,
  input  logic        Halt,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [31:0]      pending, active, active_nxt;
  logic             halt_seen;
  logic             tick, frame;
  logic [3:0]       nib;
  logic [6:0]       seg_dec;

  assign tick    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_nxt = idx + 1'b1;
  assign frame   = tick && (idx_nxt == '0);

  // A Load coinciding with the frame boundary bypasses pending so digit 0
  // of the new frame already shows the fresh word.
  assign active_nxt = frame ? (Load ? Hex : pending) : active;
  assign nib        = active_nxt[{idx_nxt, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      pending   <= '0;
      active    <= '0;
      halt_seen <= 1'b0;
      AN        <= AN_OFF;
      SEG       <= SEG_BLANK;
      DP        <= 1'b1;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      active <= active_nxt;
      if (Load) pending   <= Hex;
      if (Halt) halt_seen <= 1'b1;
      if (tick) begin
        idx <= idx_nxt;
        AN  <= ~(8'd1 << idx_nxt);
        SEG <= seg_dec;
        DP  <= ~halt_seen;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display with SCAN_DIV=4 (32-cycle frames).
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Load = 1'b0;
  logic [31:0] Hex = '0;
  logic        Halt = 1'b0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sbq[$];

  seg7_scan_display #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Hex(Hex), .Halt(Halt),
    .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  task automatic push(input string tag, input int d, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.tag = tag; e.an = an_of(d); e.seg = seg; e.dp = dp;
    sbq.push_back(e);
  endtask

  // Waits for a fresh transition of AN onto the target digit.
  task automatic wait_an(input logic [7:0] t, input int budget, output bit ok);
    logic [7:0] prev;
    ok = 1'b0;
    prev = AN;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (AN === t && prev !== t) ok = 1'b1;
      prev = AN;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Load = 1'b1; Hex = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold: AN=%h SEG=%h DP=%b expected AN=ff SEG=7f DP=1", AN, SEG, DP);
      end
    end
    Load = 1'b0; Hex = '0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (AN !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_dark_%0d: AN=%h expected ff", i, AN);
      end
    end
    @(negedge clk);
    n_checks++;
    if (AN !== 8'hFD || SEG !== 7'h40 || DP !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick: AN=%h SEG=%h DP=%b expected AN=fd SEG=40 DP=1", AN, SEG, DP);
    end
  endtask

  task automatic test_basic_frame;
    exp_t e;
    bit ok;
    Load = 1'b1; Hex = 32'h1234_5678;
    @(negedge clk);
    Load = 1'b0; Hex = '0;
    push("basic_d0", 0, 7'h00, 1'b1);
    push("basic_d3", 3, 7'h12, 1'b1);
    push("basic_d7", 7, 7'h79, 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_an(e.an, 80, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: AN=%h never reached %h", e.tag, AN, e.an);
      end else if (SEG !== e.seg || DP !== e.dp) begin
        n_fail++;
        $display("FAIL %s: SEG=%h DP=%b expected SEG=%h DP=%b", e.tag, SEG, DP, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_mid_frame_load;
    exp_t e;
    bit ok;
    wait_an(8'hF7, 80, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_sync: AN=%h never reached f7", AN);
    end
    Load = 1'b1; Hex = 32'hCAFE_BABE;
    @(negedge clk);
    Load = 1'b0; Hex = '0;
    push("mid_old_d4", 4, glyph(4'h4), 1'b1);
    push("mid_old_d5", 5, glyph(4'h3), 1'b1);
    push("mid_old_d6", 6, glyph(4'h2), 1'b1);
    push("mid_old_d7", 7, glyph(4'h1), 1'b1);
    push("mid_new_d0", 0, glyph(4'hE), 1'b1);
    push("mid_new_d1", 1, glyph(4'hB), 1'b1);
    push("mid_new_d7", 7, glyph(4'hC), 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_an(e.an, 80, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: AN=%h never reached %h", e.tag, AN, e.an);
      end else if (SEG !== e.seg || DP !== e.dp) begin
        n_fail++;
        $display("FAIL %s: SEG=%h DP=%b expected SEG=%h DP=%b", e.tag, SEG, DP, e.seg, e.dp);
      end
    end
  endtask

  // Entered right after the tick onto digit 7, so the 4th edge wraps to 0.
  task automatic test_boundary_collision;
    exp_t e;
    repeat (3) @(negedge clk);
    Load = 1'b1; Hex = 32'h0000_000F;
    push("collide_d0", 0, glyph(4'hF), 1'b1);
    @(negedge clk);
    Load = 1'b0; Hex = '0;
    e = sbq.pop_front();
    n_checks++;
    if (AN !== e.an || SEG !== e.seg || DP !== e.dp) begin
      n_fail++;
      $display("FAIL %s: AN=%h SEG=%h DP=%b expected AN=%h SEG=%h DP=%b",
               e.tag, AN, SEG, DP, e.an, e.seg, e.dp);
    end
  endtask

  task automatic test_halt;
    exp_t e;
    bit ok;
    Halt = 1'b1;
    @(negedge clk);
    Halt = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int k = 1; k <= 8; k++)
        push($sformatf("halt_f%0d_d%0d", f, k % 8), k % 8,
             (k % 8 == 0) ? glyph(4'hF) : glyph(4'h0), 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_an(e.an, 80, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: AN=%h never reached %h", e.tag, AN, e.an);
      end else if (SEG !== e.seg || DP !== e.dp) begin
        n_fail++;
        $display("FAIL %s: SEG=%h DP=%b expected SEG=%h DP=%b", e.tag, SEG, DP, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    bit ok;
    Load = 1'b1; Hex = 32'h1111_1111;
    @(negedge clk);
    Load = 1'b0; Hex = '0;
    wait_an(8'hEF, 80, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL areset_sync: AN=%h never reached ef", AN);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_async: AN=%h SEG=%h DP=%b expected AN=ff SEG=7f DP=1", AN, SEG, DP);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++)
      push($sformatf("areset_d%0d", k % 8), k % 8, glyph(4'h0), 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_an(e.an, 80, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: AN=%h never reached %h", e.tag, AN, e.an);
      end else if (SEG !== e.seg || DP !== e.dp) begin
        n_fail++;
        $display("FAIL %s: SEG=%h DP=%b expected SEG=%h DP=%b", e.tag, SEG, DP, e.seg, e.dp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_mid_frame_load;
    test_boundary_collision;
    test_halt;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
